rambam_aes_host: RTL and testbench
==================================

Name: rambam_aes_host

Overview:
- Host-side driver for the masked AES core rambam_aes_multiple_sbox; it initiates each encryption on the core's drdy_i/drdy_o handshake.
- Accepts encryption jobs (plaintext, key, mask randomness) on a valid/ready request port and issues each to the core with a one-cycle drdy_i pulse.
- Holds the core operands stable, waits for drdy_o, then captures the ciphertext and returns it on a valid/ready response port.
- Adds a watchdog that flags a core that never responds. The block replaces hand-driven testbench sequencing in system integration.

Parameters:
- d, 4: masking order width; the randomness vector is 23 entries of d bits.
- TIMEOUT, 1023: maximum cycles to wait for drdy_o after issue before an error is reported (must be at least 1).
- CNT_W, 10: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 = reset.
- job_valid  in  1  request valid.
- job_ready  out  1  request ready.
- job_plaintext  in  [0:127]  plaintext, bit 0 = MSB.
- job_key  in  [0:127]  AES-128 key.
- job_random  in  [0:22][0:d-1]  mask randomness for this job.
- res_valid  out  1  response valid.
- res_ready  in  1  response ready.
- res_ciphertext  out  [0:127]  captured ciphertext.
- res_timeout  out  1  job ended by watchdog; ciphertext is invalid.
- core_drdy_i  out  1  start pulse to core.
- core_plaintext  out  [0:127]  operand to core.
- core_key  out  [0:127]  operand to core.
- core_random_vect  out  [0:22][0:d-1]  randomness to core.
- core_drdy_o  in  1  core done.
- core_ciphertext  in  [0:127]  core result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, job_ready=1, res_valid=0, res_timeout=0, core_drdy_i=0, busy=0; all data outputs are 0; watchdog=0; drdy_o_q=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: job_ready=1. On job_valid, the job is accepted at the clock edge. Plaintext, key and random are registered onto core_plaintext, core_key and core_random_vect, and the FSM goes to ISSUE. job_ready is 0 in every other state.
- ISSUE: core_drdy_i=1 for exactly this one cycle. Watchdog clears to 0. Next state is WAIT.
- WAIT: core_drdy_i=0 and the watchdog increments each cycle.
  - Completion is a rising edge of core_drdy_o (core_drdy_o=1 with drdy_o_q=0); drdy_o_q is core_drdy_o delayed by one cycle.
  - On completion: res_ciphertext<=core_ciphertext, res_timeout<=0, next state DONE.
  - If the watchdog reaches TIMEOUT with no edge: res_ciphertext<=0, res_timeout<=1, next state DONE.
  - If the edge and the timeout occur in the same cycle, the edge wins (no error).
- A core_drdy_o edge arriving while in IDLE, ISSUE or DONE is ignored. drdy_o_q still updates every cycle, so a level held high from an earlier job does not count as a new completion.
- DONE: res_valid=1, with data and res_timeout stable until res_ready. On res_valid&&res_ready, go to IDLE. There is no same-cycle re-accept; the minimum job-to-job spacing is one IDLE cycle.
- core_* operands hold their values from acceptance until the next acceptance; they are never cleared between jobs.
- Latency: accept edge → core_drdy_i high at the next cycle. A core edge at cycle N → res_valid high at cycle N+1.
- Reset mid-operation aborts the job immediately. core_drdy_i drops asynchronously and no response is produced.
- job_valid is ignored outside IDLE; the request payload is sampled only on the accept edge.

Test Plan:
- Known-answer test with the real core (d=4, random all 4'd1): key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → res_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, res_timeout=0.
- Behavioural core model with fixed 12-cycle latency: core_drdy_i is high for exactly one cycle, one cycle after acceptance. res_valid rises one cycle after the core_drdy_o edge. busy is high throughout.
- Model that never asserts drdy_o, with TIMEOUT=20: res_valid after 20 WAIT cycles, res_timeout=1, res_ciphertext=0. The next job then completes normally with res_timeout=0.
- Backpressure: hold res_ready=0 for 50 cycles after res_valid. Data stays stable, job_ready=0, and a second job_valid is not accepted until one cycle after the response handshake.
- Core_drdy_o held high continuously from a prior job: the second job completes only on a fresh rising edge. An edge injected during DONE is ignored.
- Assert rst=0 during WAIT: all outputs go to reset values asynchronously. After release, a new job completes correctly and no stale response appears.

Source files
------------

// File: rtl/rambam_aes_host.sv
// Host-side sequencer for the masked AES core: accepts a job, pulses drdy_i,
// waits for a fresh drdy_o edge (or watchdog expiry) and returns the result.
module rambam_aes_host #(
    parameter int d       = 4,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [0:127]           job_plaintext,
    input  logic [0:127]           job_key,
    input  logic [0:22][0:d-1]     job_random,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [0:127]           res_ciphertext,
    output logic                   res_timeout,
    output logic                   core_drdy_i,
    output logic [0:127]           core_plaintext,
    output logic [0:127]           core_key,
    output logic [0:22][0:d-1]     core_random_vect,
    input  logic                   core_drdy_o,
    input  logic [0:127]           core_ciphertext,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] watchdog;
    logic [CNT_W-1:0] watchdog_inc;
    logic             drdy_o_q;
    logic             drdy_edge;

    always_comb begin
        watchdog_inc = watchdog + CNT_W'(1);
        drdy_edge    = core_drdy_o && !drdy_o_q;
    end

    // NOTE: all state here is plain flops (no memory arrays), so everything
    // is reset and every sequential assignment is non-blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            job_ready        <= 1'b1;
            res_valid        <= 1'b0;
            res_ciphertext   <= '0;
            res_timeout      <= 1'b0;
            core_drdy_i      <= 1'b0;
            core_plaintext   <= '0;
            core_key         <= '0;
            core_random_vect <= '0;
            busy             <= 1'b0;
            watchdog         <= '0;
            drdy_o_q         <= 1'b0;
        end else begin
            // Tracked in every state so a level left high from an earlier
            // job never looks like a new completion.
            drdy_o_q <= core_drdy_o;

            case (state)
                IDLE: begin
                    if (job_valid) begin
                        core_plaintext   <= job_plaintext;
                        core_key         <= job_key;
                        core_random_vect <= job_random;
                        core_drdy_i      <= 1'b1;
                        job_ready        <= 1'b0;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end

                ISSUE: begin
                    core_drdy_i <= 1'b0;
                    watchdog    <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    watchdog <= watchdog_inc;
                    // The core edge takes priority over a simultaneous expiry.
                    if (drdy_edge) begin
                        res_ciphertext <= core_ciphertext;
                        res_timeout    <= 1'b0;
                        res_valid      <= 1'b1;
                        state          <= DONE;
                    end else if (watchdog_inc == TIMEOUT_C) begin
                        res_ciphertext <= '0;
                        res_timeout    <= 1'b1;
                        res_valid      <= 1'b1;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rambam_aes_host.sv
// Directed bench for rambam_aes_host: the core is emulated by the stimulus
// thread and responses are checked against a queue by a separate monitor.
module tb_rambam_aes_host;

    localparam int D       = 4;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 5;

    typedef struct {
        logic [0:127] ct;
        logic         to;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               job_valid;
    logic               job_ready;
    logic [0:127]       job_plaintext;
    logic [0:127]       job_key;
    logic [0:22][0:D-1] job_random;
    logic               res_valid;
    logic               res_ready;
    logic [0:127]       res_ciphertext;
    logic               res_timeout;
    logic               core_drdy_i;
    logic [0:127]       core_plaintext;
    logic [0:127]       core_key;
    logic [0:22][0:D-1] core_random_vect;
    logic               core_drdy_o;
    logic [0:127]       core_ciphertext;
    logic               busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    rambam_aes_host #(
        .d       (D),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_plaintext    (job_plaintext),
        .job_key          (job_key),
        .job_random       (job_random),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_ciphertext   (res_ciphertext),
        .res_timeout      (res_timeout),
        .core_drdy_i      (core_drdy_i),
        .core_plaintext   (core_plaintext),
        .core_key         (core_key),
        .core_random_vect (core_random_vect),
        .core_drdy_o      (core_drdy_o),
        .core_ciphertext  (core_ciphertext),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Accepts a job and verifies the one-cycle issue pulse; returns in WAIT cycle 1.
    task automatic issue_job(input logic [0:127] pt, input logic [0:127] key,
                             input logic [0:22][0:D-1] rnd);
        job_valid     = 1'b1;
        job_plaintext = pt;
        job_key       = key;
        job_random    = rnd;
        tick();
        job_valid     = 1'b0;
        job_plaintext = ~pt;
        job_key       = ~key;
        job_random    = ~rnd;
        check("issue_drdy_i", core_drdy_i, 1'b1);
        check("issue_ready_busy", {job_ready, busy}, 2'b01);
        check("issue_plaintext", core_plaintext, pt);
        check("issue_key", core_key, key);
        check("issue_random", core_random_vect, rnd);
        tick();
        check("issue_pulse_width", core_drdy_i, 1'b0);
    endtask

    task automatic push_exp(input logic [0:127] ct, input logic to);
        exp_t e;
        e.ct = ct;
        e.to = to;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every response handshake against the queue.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_ciphertext", res_ciphertext, e.ct);
                check("res_timeout", res_timeout, e.to);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [0:127]       kat_pt;
        logic [0:127]       kat_key;
        logic [0:127]       kat_ct;
        logic [0:22][0:D-1] rnd_ones;

        kat_pt   = 128'h00112233445566778899aabbccddeeff;
        kat_key  = 128'h000102030405060708090a0b0c0d0e0f;
        kat_ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        rnd_ones = {23{4'h1}};

        rst             = 1'b0;
        job_valid       = 1'b0;
        job_plaintext   = '0;
        job_key         = '0;
        job_random      = '0;
        res_ready       = 1'b1;
        core_drdy_o     = 1'b0;
        core_ciphertext = '0;
        tick();
        tick();
        check("reset_ctrl", {job_ready, res_valid, res_timeout, core_drdy_i, busy}, 5'b10000);
        check("reset_core_plaintext", core_plaintext, 128'h0);
        check("reset_res_ciphertext", res_ciphertext, 128'h0);
        rst = 1'b1;
        tick();

        // Known-answer vector through a 12-cycle core: drdy_o rises at issue+12.
        issue_job(kat_pt, kat_key, rnd_ones);
        for (int i = 0; i < 11; i++) begin
            tick();
            check("latency_wait", {busy, res_valid, core_drdy_i}, 3'b100);
        end
        push_exp(kat_ct, 1'b0);
        core_ciphertext = kat_ct;
        core_drdy_o     = 1'b1;
        check("kat_not_yet_valid", res_valid, 1'b0);
        tick();
        check("kat_valid_next_cycle", {res_valid, busy, job_ready}, 3'b110);
        core_drdy_o     = 1'b0;
        core_ciphertext = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        tick();
        check("kat_back_idle", {res_valid, busy, job_ready}, 3'b001);

        // Core that never answers: 20 WAIT cycles, then a timeout response.
        push_exp(128'h0, 1'b1);
        core_ciphertext = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
        issue_job(128'h1, 128'h2, {23{4'h5}});
        for (int i = 0; i < TIMEOUT; i++) begin
            check("timeout_waiting", res_valid, 1'b0);
            tick();
        end
        check("timeout_valid", {res_valid, res_timeout}, 2'b11);
        check("timeout_ct_zero", res_ciphertext, 128'h0);
        tick();

        // Following job completes normally after a timeout.
        issue_job(128'h3, 128'h4, {23{4'ha}});
        tick();
        tick();
        push_exp(128'h0123456789abcdef_fedcba9876543210, 1'b0);
        core_ciphertext = 128'h0123456789abcdef_fedcba9876543210;
        core_drdy_o     = 1'b1;
        tick();
        check("recover_valid", {res_valid, res_timeout}, 2'b10);
        core_drdy_o = 1'b0;
        tick();

        // Backpressure: response held 50 cycles, second request waits.
        res_ready = 1'b0;
        issue_job(128'haaaa, 128'hbbbb, {23{4'h3}});
        tick();
        push_exp(128'h11112222333344445555666677778888, 1'b0);
        core_ciphertext = 128'h11112222333344445555666677778888;
        core_drdy_o     = 1'b1;  // stays high into the next job
        tick();
        core_ciphertext = 128'h0;
        job_valid       = 1'b1;
        job_plaintext   = 128'hcccc;
        job_key         = 128'hdddd;
        job_random      = {23{4'h7}};
        for (int i = 0; i < 50; i++) begin
            check("bp_stable_ct", res_ciphertext, 128'h11112222333344445555666677778888);
            check("bp_ctrl", {res_valid, job_ready, core_drdy_i}, 3'b100);
            check("bp_no_accept", core_plaintext, 128'haaaa);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("bp_idle_gap", {job_ready, core_drdy_i}, 2'b10);
        check("bp_idle_plaintext", core_plaintext, 128'haaaa);
        tick();
        job_valid = 1'b0;
        check("bp_second_issue", core_drdy_i, 1'b1);
        check("bp_second_plaintext", core_plaintext, 128'hcccc);
        check("bp_second_key", core_key, 128'hdddd);
        tick();

        // drdy_o still high from the prior job: only a fresh edge completes.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_level_ignored", res_valid, 1'b0);
        end
        core_drdy_o = 1'b0;
        tick();
        push_exp(128'h99998888777766665555444433332222, 1'b0);
        core_ciphertext = 128'h99998888777766665555444433332222;
        core_drdy_o     = 1'b1;
        res_ready       = 1'b0;
        tick();
        check("fresh_edge_valid", res_valid, 1'b1);
        core_drdy_o     = 1'b0;
        core_ciphertext = 128'h5;
        tick();
        core_drdy_o = 1'b1;  // edge during DONE
        tick();
        check("done_edge_ignored_ct", res_ciphertext, 128'h99998888777766665555444433332222);
        check("done_edge_ignored_valid", res_valid, 1'b1);
        core_drdy_o = 1'b0;
        res_ready   = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_ghost_job", {busy, res_valid, core_drdy_i}, 3'b000);
        end

        // Reset during WAIT aborts the job asynchronously.
        issue_job(128'h7777, 128'h8888, {23{4'hf}});
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_ctrl", {job_ready, res_valid, res_timeout, core_drdy_i, busy}, 5'b10000);
        check("async_rst_plaintext", core_plaintext, 128'h0);
        check("async_rst_key", core_key, 128'h0);
        check("async_rst_random", core_random_vect, 92'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        core_drdy_o = 1'b1;  // stale completion while idle
        tick();
        core_drdy_o = 1'b0;
        tick();
        check("post_rst_idle", {busy, res_valid, job_ready}, 3'b001);

        issue_job(128'h0f0e0d0c0b0a09080706050403020100, kat_key, rnd_ones);
        tick();
        tick();
        tick();
        push_exp(128'habcdef01_23456789_abcdef01_23456789, 1'b0);
        core_ciphertext = 128'habcdef01_23456789_abcdef01_23456789;
        core_drdy_o     = 1'b1;
        tick();
        check("post_rst_job_valid", {res_valid, res_timeout}, 2'b10);
        core_drdy_o = 1'b0;
        tick();
        tick();
        tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
